e_mdu: RTL and testbench

//  Multiply/divide unit in the Execute stage. Supplies HI/LO to the mfhi/mflo path that forwards from M and W.

---
 rtl/e_mdu.sv | 130 +++++++++++++
 tb/tb_e_mdu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/multu/div/divu with HI/LO
// registers, a busy flag for the hazard unit, and single-cycle mthi/mtlo writes.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic        we_hl,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2*DATA_W-1:0] mul_res, divs_res, divu_res;

  // Full 64-bit product; signed operands are sign-extended before multiplying.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              sgn);
    logic signed [2*DATA_W-1:0] ea, eb;
    ea = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    eb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; signed mode divides magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with a zero remainder.
  function automatic logic [2*DATA_W-1:0] div_full(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              sgn);
    logic [DATA_W-1:0] ma, mb, q, r;
    ma = (sgn && a[DATA_W-1]) ? (~a + 1'b1) : a;
    mb = (sgn && b[DATA_W-1]) ? (~b + 1'b1) : b;
    if (mb == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn && (a[DATA_W-1] ^ b[DATA_W-1])) q = ~q + 1'b1;
    if (sgn && a[DATA_W-1])                 r = ~r + 1'b1;
    return {r, q};
  endfunction

  always_comb begin
    mul_res  = mul_full(a_q, b_q, ~op_q[0]);
    divs_res = div_full(a_q, b_q, 1'b1);
    divu_res = div_full(a_q, b_q, 1'b0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !mdop[2]) begin
          state_d = RUN;
          op_d    = mdop[1:0];
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = mdop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (we_hl && !start) begin
          if (mdop == 3'd4) hi_d = rs_val;
          if (mdop == 3'd5) lo_d = rs_val;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          case (op_q)
            2'd0, 2'd1: {hi_d, lo_d} = mul_res;
            2'd2:       if (b_q != '0) {hi_d, lo_d} = divs_res;
            default:    if (b_q != '0) {hi_d, lo_d} = divu_res;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results and cycle-by-cycle busy.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic        we_hl;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .we_hl(we_hl),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op and check busy through each of its n busy cycles; returns
  // in the first cycle where the result should be visible.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n);
    start = 1'b1; mdop = op; rs_val = a; rt_val = b;
    tick();
    start = 1'b0; rs_val = 32'h5A5A5A5A; rt_val = 32'hA5A5A5A5;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    check_eq({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic write_hl(input logic [2:0] op, input logic [31:0] v);
    we_hl = 1'b1; mdop = op; rs_val = v;
    tick();
    we_hl = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 3'd7; we_hl = 1'b0;
    rs_val = '0; rt_val = '0;
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    tick();

    // Reset mid-op clears preloaded HI/LO and discards the multiply.
    write_hl(3'd4, 32'h00000005);
    write_hl(3'd5, 32'h00000006);
    check_eq("pre_hi", hi, 32'h00000005);
    check_eq("pre_lo", lo, 32'h00000006);
    start = 1'b1; mdop = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_hi", hi, 32'd0);
    check_eq("midrst_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("postrst_busy", {31'd0, busy}, 32'd0);
    check_eq("postrst_hi", hi, 32'd0);
    check_eq("postrst_lo", lo, 32'd0);

    run_op("mult", 3'd0, 32'hFFFFFFFF, 32'd2, 5);
    check_eq("mult_hi", hi, 32'hFFFFFFFF);
    check_eq("mult_lo", lo, 32'hFFFFFFFE);

    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5);
    check_eq("multu_hi", hi, 32'h00000001);
    check_eq("multu_lo", lo, 32'hFFFFFFFE);

    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10);
    check_eq("div_hi", hi, 32'hFFFFFFFF);
    check_eq("div_lo", lo, 32'hFFFFFFFD);

    run_op("divu", 3'd3, 32'd7, 32'd2, 10);
    check_eq("divu_hi", hi, 32'h00000001);
    check_eq("divu_lo", lo, 32'h00000003);

    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10);
    check_eq("divovf_hi", hi, 32'h00000000);
    check_eq("divovf_lo", lo, 32'h80000000);

    // Divide by zero leaves HI/LO untouched.
    write_hl(3'd4, 32'h11111111);
    write_hl(3'd5, 32'h22222222);
    run_op("divu0", 3'd3, 32'd5, 32'd0, 10);
    check_eq("divu0_hi", hi, 32'h11111111);
    check_eq("divu0_lo", lo, 32'h22222222);
    run_op("div0", 3'd2, 32'hFFFFFFF9, 32'd0, 10);
    check_eq("div0_hi", hi, 32'h11111111);
    check_eq("div0_lo", lo, 32'h22222222);

    // mthi then mtlo back to back, no busy.
    we_hl = 1'b1; mdop = 3'd4; rs_val = 32'hABCD0000;
    tick();
    check_eq("mthi_hi", hi, 32'hABCD0000);
    check_eq("mthi_busy", {31'd0, busy}, 32'd0);
    mdop = 3'd5; rs_val = 32'h00001234;
    tick();
    we_hl = 1'b0;
    check_eq("mtlo_lo", lo, 32'h00001234);
    check_eq("mtlo_hi", hi, 32'hABCD0000);
    check_eq("mtlo_busy", {31'd0, busy}, 32'd0);

    // Unused mdop with start is a no-op.
    start = 1'b1; mdop = 3'd6; rs_val = 32'hFFFF; rt_val = 32'd9;
    tick();
    start = 1'b0;
    check_eq("nop_busy", {31'd0, busy}, 32'd0);
    check_eq("nop_hi", hi, 32'hABCD0000);
    check_eq("nop_lo", lo, 32'h00001234);

    // start and we_hl together: write dropped.
    start = 1'b1; we_hl = 1'b1; mdop = 3'd4; rs_val = 32'hBEEF0000;
    tick();
    start = 1'b0; we_hl = 1'b0;
    check_eq("startwe_hi", hi, 32'hABCD0000);

    // Second start and we_hl during busy are ignored.
    start = 1'b1; mdop = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    check_eq("col_busy1", {31'd0, busy}, 32'd1);
    tick();
    check_eq("col_busy2", {31'd0, busy}, 32'd1);
    start = 1'b1; mdop = 3'd3; rs_val = 32'd9; rt_val = 32'd3;
    tick();
    start = 1'b0;
    we_hl = 1'b1; mdop = 3'd4; rs_val = 32'hDEAD0000;
    check_eq("col_busy3", {31'd0, busy}, 32'd1);
    tick();
    we_hl = 1'b0;
    check_eq("col_busy4", {31'd0, busy}, 32'd1);
    check_eq("col_we_hi", hi, 32'hABCD0000);
    tick();
    check_eq("col_busy5", {31'd0, busy}, 32'd1);
    tick();
    check_eq("col_done", {31'd0, busy}, 32'd0);
    check_eq("col_hi", hi, 32'h00000000);
    check_eq("col_lo", lo, 32'h0000000C);
    tick();
    check_eq("col_idle", {31'd0, busy}, 32'd0);
    check_eq("col_lo2", lo, 32'h0000000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
